rtc_clock: RTL and testbench

BCD time-of-day counter (hh:mm:ss) for the RTC subsystem. It runs from the 32.768 kHz RTC reference clock through an internal seconds prescaler. At the 23:59:59 -> 00:00:00 rollover it emits the one-cycle new_day pulse that drives the date counter's new_day input. It also provides software time load/readback and a one-shot time-of-day alarm.

---
 rtl/rtc_clock.sv | 157 +++++++++++++++
 tb/tb_rtc_clock.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rtc_clock.sv
// ---------------------------------------------------------------------------
// rtc_clock - BCD time-of-day counter (hh:mm:ss) for the RTC subsystem.
//
// A prescaler divides the RTC reference clock down to one tick per second.
// Each tick advances the BCD time by one second. Three registered one-cycle
// pulses are produced on the cycle the new time first appears:
//   - sec_tick_o : every second
//   - new_day_o  : on the 23:59:59 -> 00:00:00 rollover
//   - alarm_o    : when the new time matches alarm_i[21:0] (alarm enabled)
// Software may load the time at any moment; a load clears the prescaler and
// cancels a tick that lands in the same cycle.
//
// Ports:
//   clk_i          in   1  RTC reference clock
//   rstn_i         in   1  asynchronous active-low reset
//   en_i           in   1  count enable (0 freezes prescaler and time)
//   time_update_i  in   1  one-cycle load strobe
//   time_i         in  32  load value {10'b0, hh[21:16], 1'b0, mm[14:8], 1'b0, ss[6:0]}
//   time_o         out 32  current time, same packing, unused bits 0
//   alarm_en_i     in   1  alarm compare enable
//   alarm_i        in  32  alarm time, same packing (bits [31:22] ignored)
//   alarm_o        out  1  one-cycle alarm pulse
//   new_day_o      out  1  one-cycle day-rollover pulse
//   sec_tick_o     out  1  one-cycle pulse per second
// ---------------------------------------------------------------------------
module rtc_clock #(
  parameter int TICKS_PER_SEC = 32768,
  parameter int PRESC_W       = 15
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic        time_update_i,
  input  logic [31:0] time_i,
  output logic [31:0] time_o,
  input  logic        alarm_en_i,
  input  logic [31:0] alarm_i,
  output logic        alarm_o,
  output logic        new_day_o,
  output logic        sec_tick_o
);

  localparam logic [PRESC_W-1:0] LP_PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  // Seconds/minutes field increment: returns {carry, next_value}.
  // Out-of-range units wrap mod 16 without carry; tens wrap mod 8.
  function automatic logic [7:0] bcd_inc_ms(input logic [6:0] v);
    logic [7:0] res;
    if (v == 7'h59) begin
      res = {1'b1, 7'h00};
    end else if (v[3:0] == 4'd9) begin
      res = {1'b0, v[6:4] + 3'd1, 4'd0};
    end else begin
      res = {1'b0, v[6:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Hours field increment: returns {day_carry, next_value}; tens wrap mod 4.
  function automatic logic [6:0] bcd_inc_hh(input logic [5:0] v);
    logic [6:0] res;
    if (v == 6'h23) begin
      res = {1'b1, 6'h00};
    end else if (v[3:0] == 4'd9) begin
      res = {1'b0, v[5:4] + 2'd1, 4'd0};
    end else begin
      res = {1'b0, v[5:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  logic [PRESC_W-1:0] r_presc;
  logic [5:0]         r_hh;
  logic [6:0]         r_mm;
  logic [6:0]         r_ss;
  logic               r_sec_tick;
  logic               r_new_day;
  logic               r_alarm;

  logic               w_tick;
  logic               w_ss_c;
  logic               w_mm_c;
  logic               w_day_c;
  logic [6:0]         w_ss_nx;
  logic [6:0]         w_mm_nx;
  logic [5:0]         w_hh_nx;
  logic [21:0]        w_time_nx;
  logic               w_unused;

  // Packing bits of the load/alarm words carry no state.
  assign w_unused = ^{time_i[31:22], time_i[15], time_i[7], alarm_i[31:22]};

  assign w_tick = en_i && (r_presc == LP_PRESC_LAST);

  // Next BCD time, rippling carries from seconds to hours.
  always_comb begin
    {w_ss_c, w_ss_nx} = bcd_inc_ms(r_ss);
    if (w_ss_c) begin
      {w_mm_c, w_mm_nx} = bcd_inc_ms(r_mm);
    end else begin
      w_mm_c  = 1'b0;
      w_mm_nx = r_mm;
    end
    if (w_mm_c) begin
      {w_day_c, w_hh_nx} = bcd_inc_hh(r_hh);
    end else begin
      w_day_c = 1'b0;
      w_hh_nx = r_hh;
    end
    w_time_nx = {w_hh_nx, 1'b0, w_mm_nx, 1'b0, w_ss_nx};
  end

  // Prescaler, time registers and the three output pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_presc    <= '0;
      r_hh       <= 6'h00;
      r_mm       <= 7'h00;
      r_ss       <= 7'h00;
      r_sec_tick <= 1'b0;
      r_new_day  <= 1'b0;
      r_alarm    <= 1'b0;
    end else if (time_update_i) begin
      // A load wins over a coincident tick; that tick is discarded.
      r_presc    <= '0;
      r_hh       <= time_i[21:16];
      r_mm       <= time_i[14:8];
      r_ss       <= time_i[6:0];
      r_sec_tick <= 1'b0;
      r_new_day  <= 1'b0;
      r_alarm    <= 1'b0;
    end else if (w_tick) begin
      r_presc    <= '0;
      r_hh       <= w_time_nx[21:16];
      r_mm       <= w_time_nx[14:8];
      r_ss       <= w_time_nx[6:0];
      r_sec_tick <= 1'b1;
      r_new_day  <= w_day_c;
      r_alarm    <= alarm_en_i && (w_time_nx == alarm_i[21:0]);
    end else begin
      if (en_i) begin
        r_presc <= r_presc + {{(PRESC_W-1){1'b0}}, 1'b1};
      end else begin
        r_presc <= r_presc;
      end
      r_sec_tick <= 1'b0;
      r_new_day  <= 1'b0;
      r_alarm    <= 1'b0;
    end
  end

  assign time_o     = {10'b0, r_hh, 1'b0, r_mm, 1'b0, r_ss};
  assign sec_tick_o = r_sec_tick;
  assign new_day_o  = r_new_day;
  assign alarm_o    = r_alarm;

endmodule

// File: tb/tb_rtc_clock.sv
module tb_rtc_clock;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic        time_update_i;
  logic [31:0] time_i;
  logic [31:0] time_o;
  logic        alarm_en_i;
  logic [31:0] alarm_i;
  logic        alarm_o;
  logic        new_day_o;
  logic        sec_tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_clock #(.TICKS_PER_SEC(4), .PRESC_W(2)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .time_update_i(time_update_i),
    .time_i       (time_i),
    .time_o       (time_o),
    .alarm_en_i   (alarm_en_i),
    .alarm_i      (alarm_i),
    .alarm_o      (alarm_o),
    .new_day_o    (new_day_o),
    .sec_tick_o   (sec_tick_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] load;
    logic [31:0] alarm;
    logic        alarm_en;
    int          cycles;
    logic [31:0] exp_time;
    int          exp_nd;
    int          exp_al;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    time_i        = v;
    time_update_i = 1'b1;
    step();
    time_update_i = 1'b0;
  endtask

  initial begin
    int nd_cnt;
    int al_cnt;
    int st_cnt;
    logic [31:0] t_hold;

    vecs[0]  = '{32'h00235958, 32'h00000000, 1'b0, 8, 32'h00000000, 1, 0};
    vecs[1]  = '{32'h00095959, 32'h00000000, 1'b0, 4, 32'h00100000, 0, 0};
    vecs[2]  = '{32'h00122959, 32'h00123000, 1'b1, 4, 32'h00123000, 0, 1};
    vecs[3]  = '{32'h00122959, 32'h00123000, 1'b0, 4, 32'h00123000, 0, 0};
    vecs[4]  = '{32'h00123000, 32'h00123000, 1'b1, 3, 32'h00123000, 0, 0};
    vecs[5]  = '{32'h00122959, 32'hFFD23000, 1'b1, 4, 32'h00123000, 0, 1};
    vecs[6]  = '{32'h00235959, 32'h00000000, 1'b1, 4, 32'h00000000, 1, 1};
    vecs[7]  = '{32'h0000005A, 32'h00000000, 1'b0, 4, 32'h0000005B, 0, 0};
    vecs[8]  = '{32'h0000005F, 32'h00000000, 1'b0, 4, 32'h00000050, 0, 0};
    vecs[9]  = '{32'h00005979, 32'h00000000, 1'b0, 4, 32'h00005900, 0, 0};
    vecs[10] = '{32'h00000959, 32'h00000000, 1'b0, 4, 32'h00001000, 0, 0};
    vecs[11] = '{32'h00195959, 32'h00000000, 1'b0, 4, 32'h00200000, 0, 0};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 4, 32'h003F7F70, 0, 0};
    vecs[13] = '{32'h00000009, 32'h00000000, 1'b0, 8, 32'h00000011, 0, 0};
    vecs[14] = '{32'h000F5959, 32'h00000000, 1'b0, 4, 32'h00000000, 0, 0};
    vecs[15] = '{32'h00395959, 32'h00000000, 1'b0, 4, 32'h00000000, 0, 0};

    rstn_i        = 1'b0;
    en_i          = 1'b0;
    time_update_i = 1'b0;
    time_i        = 32'h0;
    alarm_en_i    = 1'b0;
    alarm_i       = 32'h0;

    // Reset state and first tick after release.
    step();
    step();
    check("rst_time", time_o, 32'h0);
    check("rst_pulses", {29'b0, alarm_o, new_day_o, sec_tick_o}, 32'h0);
    rstn_i = 1'b1;
    en_i   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("first_tick_early", {29'b0, alarm_o, new_day_o, sec_tick_o}, 32'h0);
    end
    step();
    check("first_tick", {31'b0, sec_tick_o}, 32'h1);
    check("first_tick_time", time_o, 32'h00000001);
    check("first_tick_other", {30'b0, alarm_o, new_day_o}, 32'h0);

    // Table-driven load + run vectors.
    for (int i = 0; i < NV; i++) begin
      alarm_i    = vecs[i].alarm;
      alarm_en_i = vecs[i].alarm_en;
      load(vecs[i].load);
      nd_cnt = 0;
      al_cnt = 0;
      st_cnt = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        if (new_day_o) begin
          nd_cnt++;
          check($sformatf("v%0d_nd_align_time", i), time_o, 32'h0);
          check($sformatf("v%0d_nd_align_tick", i), {31'b0, sec_tick_o}, 32'h1);
        end
        if (alarm_o) begin
          al_cnt++;
          check($sformatf("v%0d_al_align_tick", i), {31'b0, sec_tick_o}, 32'h1);
        end
        if (sec_tick_o) st_cnt++;
      end
      check($sformatf("v%0d_time", i), time_o, vecs[i].exp_time);
      check($sformatf("v%0d_new_day_cnt", i), 32'(nd_cnt), 32'(vecs[i].exp_nd));
      check($sformatf("v%0d_alarm_cnt", i), 32'(al_cnt), 32'(vecs[i].exp_al));
      check($sformatf("v%0d_sec_tick_cnt", i), 32'(st_cnt), 32'(vecs[i].cycles / 4));
    end
    alarm_en_i = 1'b0;

    // Load colliding with a tick at 23:59:59.
    load(32'h00235959);
    step();
    step();
    step();
    time_i        = 32'h00010203;
    time_update_i = 1'b1;
    step();
    time_update_i = 1'b0;
    check("coll_time", time_o, 32'h00010203);
    check("coll_pulses", {29'b0, alarm_o, new_day_o, sec_tick_o}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("coll_no_early_tick", {31'b0, sec_tick_o}, 32'h0);
    end
    step();
    check("coll_next_tick", {31'b0, sec_tick_o}, 32'h1);
    check("coll_next_time", time_o, 32'h00010204);

    // Enable low for 10 cycles mid-second delays the tick by 10 cycles.
    load(32'h00000500);
    step();
    step();
    en_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("frz_time", time_o, 32'h00000500);
      check("frz_tick", {31'b0, sec_tick_o}, 32'h0);
    end
    en_i = 1'b1;
    step();
    check("frz_resume_early", {31'b0, sec_tick_o}, 32'h0);
    step();
    check("frz_resume_tick", {31'b0, sec_tick_o}, 32'h1);
    check("frz_resume_time", time_o, 32'h00000501);

    // Asynchronous reset mid-second while a tick pulse is high.
    load(32'h00121212);
    for (int c = 0; c < 4; c++) step();
    t_hold = time_o;
    check("arst_pre_time", t_hold, 32'h00121213);
    check("arst_pre_tick", {31'b0, sec_tick_o}, 32'h1);
    rstn_i = 1'b0;
    #1;
    check("arst_time", time_o, 32'h0);
    check("arst_pulses", {29'b0, alarm_o, new_day_o, sec_tick_o}, 32'h0);
    step();
    rstn_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("arst_presc_clear", {31'b0, sec_tick_o}, 32'h0);
    end
    step();
    check("arst_first_tick", {31'b0, sec_tick_o}, 32'h1);
    check("arst_first_time", time_o, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
